// File: rtl/cae_dispatch_ctl_if.sv
// Dispatcher, core-side and CSR signal bundle for cae_dispatch_ctl.
// The slave modport is the controller; the master modport is the host/core side.
interface cae_dispatch_ctl_if #(
    parameter int NUM_CORES = 4,
    parameter int GVT_W     = 14
);
    logic                       disp_inst_vld;
    logic [4:0]                 disp_inst;
    logic [17:0]                disp_aeg_idx;
    logic                       disp_aeg_rd;
    logic                       disp_aeg_wr;
    logic [63:0]                disp_aeg_wr_data;
    logic [17:0]                disp_aeg_cnt;
    logic [15:0]                disp_exception;
    logic                       disp_idle;
    logic                       disp_stall;
    logic                       disp_rtn_data_vld;
    logic [63:0]                disp_rtn_data;
    logic [47:0]                core_base_addr;
    logic                       core_start;
    logic                       core_run;
    logic [NUM_CORES-1:0]       core_done;
    logic [NUM_CORES*GVT_W-1:0] core_gvt;
    logic                       csr_wr_vld;
    logic                       csr_rd_vld;
    logic [15:0]                csr_address;
    logic [63:0]                csr_wr_data;
    logic                       csr_rd_ack;
    logic [63:0]                csr_rd_data;

    modport master (
        output disp_inst_vld, disp_inst, disp_aeg_idx, disp_aeg_rd, disp_aeg_wr,
               disp_aeg_wr_data, core_done, core_gvt, csr_wr_vld, csr_rd_vld,
               csr_address, csr_wr_data,
        input  disp_aeg_cnt, disp_exception, disp_idle, disp_stall, disp_rtn_data_vld,
               disp_rtn_data, core_base_addr, core_start, core_run, csr_rd_ack, csr_rd_data
    );

    modport slave (
        input  disp_inst_vld, disp_inst, disp_aeg_idx, disp_aeg_rd, disp_aeg_wr,
               disp_aeg_wr_data, core_done, core_gvt, csr_wr_vld, csr_rd_vld,
               csr_address, csr_wr_data,
        output disp_aeg_cnt, disp_exception, disp_idle, disp_stall, disp_rtn_data_vld,
               disp_rtn_data, core_base_addr, core_start, core_run, csr_rd_ack, csr_rd_data
    );
endinterface

// File: rtl/cae_dispatch_ctl.sv
// Dispatch controller: AEG register file, start/run/finish sequencing of the
// attached cores, GVT minimum reduction, run-cycle counting and CSR readback.
module cae_dispatch_ctl #(
    parameter int NA        = 8,
    parameter int NB        = 3,
    parameter int NUM_CORES = 4,
    parameter int GVT_W     = 14,
    parameter int CNT_W     = 32
) (
    input logic               clk,
    input logic               i_reset,
    cae_dispatch_ctl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        RUNNING  = 2'd2,
        FINISHED = 2'd3
    } state_t;

    state_t               state_r;
    logic                 start_r;
    logic                 core_start_r;
    logic                 core_run_r;
    logic [63:0]          aeg_r [NA];
    logic [NUM_CORES-1:0] done_r;
    logic [GVT_W-1:0]     cap_r [NUM_CORES];
    logic [CNT_W-1:0]     cnt_r;
    logic [15:0]          exc_r;
    logic                 rtn_vld_r;
    logic [63:0]          rtn_data_r;
    logic                 csr_ack_r;
    logic [63:0]          csr_data_r;

    logic                 start_cmd_s;
    logic                 bad_inst_s;
    logic                 idx_ok_s;
    logic                 bad_idx_s;
    logic [NB-1:0]        idx_s;
    logic                 running_s;
    logic                 all_done_s;
    logic                 abort_s;
    logic                 timeout_s;
    logic                 end_s;
    logic [CNT_W-1:0]     cnt_inc_s;
    logic [63:0]          gvt_min_s;
    logic                 unused_s;

    assign unused_s = ^bus.csr_wr_data;

    // Request decode, run-termination causes and the GVT minimum.
    always_comb begin
        start_cmd_s = bus.disp_inst_vld && (bus.disp_inst == 5'd0);
        bad_inst_s  = bus.disp_inst_vld && (bus.disp_inst != 5'd0);
        idx_ok_s    = (bus.disp_aeg_idx < 18'(NA));
        bad_idx_s   = (bus.disp_aeg_rd || bus.disp_aeg_wr) && !idx_ok_s;
        idx_s       = bus.disp_aeg_idx[NB-1:0];
        running_s   = (state_r == RUNNING);
        all_done_s  = running_s && (&(done_r | bus.core_done));
        abort_s     = running_s && bus.csr_wr_vld && (bus.csr_address == 16'h0002);
        cnt_inc_s   = (&cnt_r) ? cnt_r : cnt_r + CNT_W'(1);
        // The limit is the number of RUNNING cycles: compare the value the counter takes this cycle.
        timeout_s   = running_s && (aeg_r[2] != 64'd0) && (cnt_inc_s == aeg_r[2][CNT_W-1:0]);
        end_s       = all_done_s || abort_s || timeout_s;
        gvt_min_s   = {64{1'b1}};
        for (int i = 0; i < NUM_CORES; i++) begin
            if (done_r[i] && (64'(cap_r[i]) < gvt_min_s)) begin
                gvt_min_s = 64'(cap_r[i]);
            end else begin
                gvt_min_s = gvt_min_s;
            end
        end
    end

    // Run-control FSM with registered core strobes.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_r      <= IDLE;
            core_start_r <= 1'b0;
            core_run_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    core_run_r <= 1'b0;
                    if (start_r) begin
                        state_r      <= START;
                        core_start_r <= 1'b1;
                    end else begin
                        core_start_r <= 1'b0;
                    end
                end
                START: begin
                    state_r      <= RUNNING;
                    core_start_r <= 1'b0;
                    core_run_r   <= 1'b1;
                end
                RUNNING: begin
                    core_start_r <= 1'b0;
                    if (end_s) begin
                        state_r    <= FINISHED;
                        core_run_r <= 1'b0;
                    end else begin
                        core_run_r <= 1'b1;
                    end
                end
                FINISHED: begin
                    state_r      <= IDLE;
                    core_start_r <= 1'b0;
                    core_run_r   <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    core_start_r <= 1'b0;
                    core_run_r   <= 1'b0;
                end
            endcase
        end
    end

    // Per-core done latches, GVT captures and the saturating run counter.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            done_r <= '0;
            cnt_r  <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                cap_r[i] <= '0;
            end
        end else begin
            case (state_r)
                START: begin
                    done_r <= '0;
                    cnt_r  <= '0;
                end
                RUNNING: begin
                    cnt_r  <= cnt_inc_s;
                    done_r <= done_r | bus.core_done;
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (bus.core_done[i]) begin
                            cap_r[i] <= bus.core_gvt[i*GVT_W +: GVT_W];
                        end
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // AEG file; the dispatcher write is last so it overrides the end-of-run results.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NA; i++) begin
                aeg_r[i] <= 64'd0;
            end
        end else begin
            if (state_r == FINISHED) begin
                aeg_r[1] <= gvt_min_s;
                aeg_r[3] <= 64'(cnt_r);
            end
            if (bus.disp_aeg_wr && idx_ok_s) begin
                aeg_r[idx_s] <= bus.disp_aeg_wr_data;
            end
        end
    end

    // Start capture, exception pulses and dispatcher/CSR read responses.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            start_r    <= 1'b0;
            exc_r      <= 16'd0;
            rtn_vld_r  <= 1'b0;
            rtn_data_r <= 64'd0;
            csr_ack_r  <= 1'b0;
            csr_data_r <= 64'd0;
        end else begin
            start_r   <= start_cmd_s;
            exc_r     <= {12'd0,
                          abort_s && !all_done_s,
                          timeout_s && !all_done_s && !abort_s,
                          bad_idx_s,
                          bad_inst_s};
            rtn_vld_r <= bus.disp_aeg_rd;
            if (bus.disp_aeg_rd && idx_ok_s) begin
                rtn_data_r <= aeg_r[idx_s];
            end else begin
                rtn_data_r <= 64'd0;
            end
            csr_ack_r <= bus.csr_rd_vld;
            if (bus.csr_rd_vld) begin
                case (bus.csr_address)
                    16'd0:   csr_data_r <= {60'd0, 2'(state_r), 2'b00};
                    16'd1:   csr_data_r <= aeg_r[1];
                    16'd3:   csr_data_r <= 64'(cnt_r);
                    16'd4:   csr_data_r <= 64'(done_r);
                    default: csr_data_r <= 64'd0;
                endcase
            end else begin
                csr_data_r <= 64'd0;
            end
        end
    end

    assign bus.disp_aeg_cnt      = 18'(NA);
    assign bus.disp_exception    = exc_r;
    assign bus.disp_idle         = (state_r == IDLE) && !start_r;
    assign bus.disp_stall        = (state_r != IDLE) || start_r || start_cmd_s;
    assign bus.disp_rtn_data_vld = rtn_vld_r;
    assign bus.disp_rtn_data     = rtn_data_r;
    assign bus.core_base_addr    = aeg_r[0][47:0];
    assign bus.core_start        = core_start_r;
    assign bus.core_run          = core_run_r;
    assign bus.csr_rd_ack        = csr_ack_r;
    assign bus.csr_rd_data       = csr_data_r;
endmodule

// File: tb/tb_cae_dispatch_ctl.sv
// Directed bench for cae_dispatch_ctl: a run-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_cae_dispatch_ctl;
    localparam int NA = 8;
    localparam int NC = 4;
    localparam int GW = 14;
    localparam int CW = 32;

    logic clk;
    logic i_reset;

    cae_dispatch_ctl_if #(.NUM_CORES(NC), .GVT_W(GW)) bus ();

    cae_dispatch_ctl #(.NA(NA), .NB(3), .NUM_CORES(NC), .GVT_W(GW), .CNT_W(CW)) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: run phase (0 idle, 1 start, 2 running, 3 finished) and architectural values.
    int          m_phase = 0;
    bit          m_start_pending = 0;
    logic [63:0] m_aeg [NA];
    bit   [NC-1:0] m_latched = '0;
    int unsigned m_cap [NC];
    longint unsigned m_count = 0;
    logic [15:0] e_exc = 16'd0;
    bit          e_rtn_vld = 0;
    logic [63:0] e_rtn = 64'd0;
    bit          e_ack = 0;
    logic [63:0] e_csr = 64'd0;

    function automatic logic [63:0] run_result();
        longint unsigned vals[$];
        longint unsigned lo[$];
        for (int i = 0; i < NC; i++) if (m_latched[i]) vals.push_back(longint'(m_cap[i]));
        if (vals.size() == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
        lo = vals.min();
        return lo[0];
    endfunction

    task automatic model_step();
        int   next_phase;
        int   idx;
        bit   finish_all;
        bit   abort;
        bit   tmo;
        if (i_reset) begin
            m_phase = 0; m_start_pending = 0; m_latched = '0; m_count = 0;
            for (int i = 0; i < NA; i++) m_aeg[i] = 64'd0;
            for (int i = 0; i < NC; i++) m_cap[i] = 0;
            e_exc = 16'd0; e_rtn_vld = 0; e_rtn = 64'd0; e_ack = 0; e_csr = 64'd0;
            return;
        end
        idx = int'(bus.disp_aeg_idx);
        e_exc = 16'd0;
        e_exc[0] = bus.disp_inst_vld && bus.disp_inst != 5'd0;
        e_exc[1] = (bus.disp_aeg_rd || bus.disp_aeg_wr) && idx >= NA;
        e_rtn_vld = bus.disp_aeg_rd;
        e_rtn = (idx < NA) ? m_aeg[idx] : 64'd0;
        e_ack = bus.csr_rd_vld;
        case (int'(bus.csr_address))
            0:       e_csr = 64'(m_phase * 4);
            1:       e_csr = m_aeg[1];
            3:       e_csr = m_count;
            4:       e_csr = 64'(m_latched);
            default: e_csr = 64'd0;
        endcase
        next_phase = m_phase;
        if (m_phase == 0 && m_start_pending) next_phase = 1;
        if (m_phase == 1) begin
            m_latched = '0; m_count = 0; next_phase = 2;
        end
        if (m_phase == 2) begin
            finish_all = ((m_latched | bus.core_done) == {NC{1'b1}});
            if (m_count < 64'hFFFF_FFFF) m_count = m_count + 1;
            tmo   = (m_aeg[2] != 64'd0) && (m_count == longint'(m_aeg[2][CW-1:0]));
            abort = bus.csr_wr_vld && bus.csr_address == 16'h0002;
            for (int i = 0; i < NC; i++) begin
                if (bus.core_done[i]) begin
                    m_latched[i] = 1'b1;
                    m_cap[i] = int'(bus.core_gvt[i*GW +: GW]);
                end
            end
            if (finish_all) next_phase = 3;
            else if (abort) begin next_phase = 3; e_exc[3] = 1'b1; end
            else if (tmo) begin next_phase = 3; e_exc[2] = 1'b1; end
        end
        if (m_phase == 3) begin
            m_aeg[1] = run_result();
            m_aeg[3] = m_count;
            next_phase = 0;
        end
        if (bus.disp_aeg_wr && idx < NA) m_aeg[idx] = bus.disp_aeg_wr_data;
        m_start_pending = bus.disp_inst_vld && bus.disp_inst == 5'd0;
        m_phase = next_phase;
    endtask

    initial begin
        for (int i = 0; i < NA; i++) m_aeg[i] = 64'd0;
        for (int i = 0; i < NC; i++) m_cap[i] = 0;
        forever begin
            @(posedge clk or posedge i_reset);
            model_step();
        end
    end

    // Cycle compare: outputs sampled on the falling edge against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("aeg_cnt", 64'(bus.disp_aeg_cnt), 64'(NA));
            chk("exception", 64'(bus.disp_exception), 64'(e_exc));
            chk("idle", 64'(bus.disp_idle), 64'(m_phase == 0 && !m_start_pending));
            chk("stall", 64'(bus.disp_stall),
                64'(m_phase != 0 || m_start_pending || (bus.disp_inst_vld && bus.disp_inst == 5'd0)));
            chk("rtn_vld", 64'(bus.disp_rtn_data_vld), 64'(e_rtn_vld));
            if (e_rtn_vld) chk("rtn_data", bus.disp_rtn_data, e_rtn);
            chk("base_addr", 64'(bus.core_base_addr), 64'(m_aeg[0][47:0]));
            chk("core_start", 64'(bus.core_start), 64'(m_phase == 1));
            chk("core_run", 64'(bus.core_run), 64'(m_phase == 2));
            chk("csr_ack", 64'(bus.csr_rd_ack), 64'(e_ack));
            if (e_ack) chk("csr_data", bus.csr_rd_data, e_csr);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic aeg_write(input int idx, input logic [63:0] data);
        bus.disp_aeg_wr = 1'b1; bus.disp_aeg_idx = 18'(idx); bus.disp_aeg_wr_data = data;
        tick();
        bus.disp_aeg_wr = 1'b0;
    endtask

    task automatic aeg_read(input int idx, output logic [63:0] data, output logic vld);
        bus.disp_aeg_rd = 1'b1; bus.disp_aeg_idx = 18'(idx);
        tick();
        bus.disp_aeg_rd = 1'b0;
        data = bus.disp_rtn_data; vld = bus.disp_rtn_data_vld;
    endtask

    task automatic csr_read(input int addr, output logic [63:0] data);
        bus.csr_rd_vld = 1'b1; bus.csr_address = 16'(addr);
        tick();
        bus.csr_rd_vld = 1'b0;
        chk("csr_ack_lit", 64'(bus.csr_rd_ack), 64'd1);
        data = bus.csr_rd_data;
    endtask

    task automatic do_start();
        bus.disp_inst_vld = 1'b1; bus.disp_inst = 5'd0;
        tick();
        bus.disp_inst_vld = 1'b0;
        tick();
        tick();
    endtask

    task automatic core_pulse(input int core, input int gvt);
        bus.core_done = '0;
        bus.core_done[core] = 1'b1;
        bus.core_gvt[core*GW +: GW] = GW'(gvt);
        tick();
        bus.core_done = '0;
    endtask

    logic [63:0] rd;
    logic        rv;
    int          n;

    initial begin
        i_reset = 1'b1;
        bus.disp_inst_vld = 1'b0; bus.disp_inst = 5'd0; bus.disp_aeg_idx = 18'd0;
        bus.disp_aeg_rd = 1'b0; bus.disp_aeg_wr = 1'b0; bus.disp_aeg_wr_data = 64'd0;
        bus.core_done = '0; bus.core_gvt = '0;
        bus.csr_wr_vld = 1'b0; bus.csr_rd_vld = 1'b0; bus.csr_address = 16'd0; bus.csr_wr_data = 64'd0;
        repeat (3) tick();
        chk("rst_idle", 64'(bus.disp_idle), 64'd1);
        chk("rst_stall", 64'(bus.disp_stall), 64'd0);
        chk("rst_run", 64'(bus.core_run), 64'd0);
        i_reset = 1'b0;
        tick();

        // Normal run; core 1 reports twice and only its last capture counts.
        aeg_write(0, 64'h0000_1234_5678_9ABC);
        chk("base_lit", 64'(bus.core_base_addr), 64'h1234_5678_9ABC);
        bus.csr_wr_vld = 1'b1; bus.csr_address = 16'h0002;
        tick();
        bus.csr_wr_vld = 1'b0;
        do_start();
        chk("run_lit", 64'(bus.core_run), 64'd1);
        core_pulse(1, 50);
        core_pulse(0, 40);
        core_pulse(1, 25);
        core_pulse(2, 31);
        core_pulse(3, 99);
        chk("n_done_run", 64'(bus.core_run), 64'd0);
        chk("n_exc", 64'(bus.disp_exception), 64'd0);
        tick();
        chk("n_idle", 64'(bus.disp_idle), 64'd1);
        csr_read(1, rd);
        chk("n_gvt", rd, 64'd25);

        // Timeout with two silent cores.
        aeg_write(2, 64'd100);
        do_start();
        core_pulse(0, 7);
        core_pulse(1, 9);
        n = 0;
        while (bus.core_run === 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("t_latency", 64'(n), 64'd98);
        chk("t_exc", 64'(bus.disp_exception), 64'h0004);
        tick();
        csr_read(1, rd);
        chk("t_gvt", rd, 64'd7);
        csr_read(3, rd);
        chk("t_count", rd, 64'd100);

        // Last core done on the limit cycle: normal completion wins.
        aeg_write(2, 64'd10);
        do_start();
        core_pulse(0, 5);
        core_pulse(1, 6);
        core_pulse(2, 7);
        repeat (6) tick();
        core_pulse(3, 3);
        chk("s_run", 64'(bus.core_run), 64'd0);
        chk("s_exc", 64'(bus.disp_exception), 64'd0);
        tick();
        csr_read(1, rd);
        chk("s_gvt", rd, 64'd3);
        csr_read(3, rd);
        chk("s_count", rd, 64'd10);

        // CSR abort with no cores done.
        aeg_write(2, 64'd0);
        do_start();
        repeat (3) tick();
        csr_read(4, rd);
        chk("a_latches", rd, 64'd0);
        bus.csr_wr_vld = 1'b1; bus.csr_address = 16'h0002;
        tick();
        bus.csr_wr_vld = 1'b0;
        chk("a_exc", 64'(bus.disp_exception), 64'h0008);
        tick();
        csr_read(1, rd);
        chk("a_gvt", rd, 64'hFFFF_FFFF_FFFF_FFFF);

        // AEG access corners.
        aeg_write(9, 64'h0000_0000_0000_DEAD);
        chk("x_exc_idx", 64'(bus.disp_exception), 64'h0002);
        aeg_read(1, rd, rv);
        chk("x_alias", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        aeg_write(2, 64'd77);
        aeg_read(2, rd, rv);
        chk("x_rd_vld", 64'(rv), 64'd1);
        chk("x_rd_data", rd, 64'd77);
        tick();
        chk("x_rd_once", 64'(bus.disp_rtn_data_vld), 64'd0);
        aeg_read(9, rd, rv);
        chk("x_rd_oob", rd, 64'd0);
        chk("x_exc_rd", 64'(bus.disp_exception), 64'h0002);
        bus.disp_inst_vld = 1'b1; bus.disp_inst = 5'd5;
        tick();
        bus.disp_inst_vld = 1'b0;
        chk("x_exc_inst", 64'(bus.disp_exception), 64'h0001);
        chk("x_no_start", 64'(bus.disp_idle), 64'd1);

        // Reset in the middle of a run.
        aeg_write(2, 64'd0);
        do_start();
        core_pulse(0, 11);
        tick();
        i_reset = 1'b1;
        #1;
        chk("r_run", 64'(bus.core_run), 64'd0);
        tick();
        tick();
        i_reset = 1'b0;
        tick();
        csr_read(0, rd);
        chk("r_state", rd, 64'd0);
        csr_read(1, rd);
        chk("r_gvt", rd, 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cae_dispatch_ctl.md
CAE_DISPATCH_CTL -- requirements
Module: cae_dispatch_ctl

Interface
REQ-001 SHALL have parameter NA, default 8: number of implemented AEG registers, 4 <= NA <= 2^NB.
REQ-002 SHALL have parameter NB, default 3: AEG index bits decoded.
REQ-003 SHALL have parameter NUM_CORES, default 4: number of attached processing cores, 1..16.
REQ-004 SHALL have parameter GVT_W, default 14: per-core GVT width, <= 64.
REQ-005 SHALL have parameter CNT_W, default 32: run-cycle counter width, <= 64.
REQ-006 SHALL have one clock and asynchronous, active-high reset: clk in 1, personality clock; i_reset in 1, asynchronous active-high reset.
REQ-007 SHALL have dispatch inputs: disp_inst_vld in 1; disp_inst in 5; disp_aeg_idx in 18; disp_aeg_rd in 1; disp_aeg_wr in 1; disp_aeg_wr_data in 64.
REQ-008 SHALL have dispatch outputs: disp_aeg_cnt out 18, constant NA; disp_exception out 16; disp_idle out 1; disp_stall out 1; disp_rtn_data_vld out 1; disp_rtn_data out 64.
REQ-009 SHALL have core-side ports: core_base_addr out 48, AEG[0][47:0]; core_start out 1, one-cycle pulse; core_run out 1, high while running; core_done in NUM_CORES; core_gvt in NUM_CORES*GVT_W, core i at [i*GVT_W +: GVT_W].
REQ-010 SHALL have CSR ports: csr_wr_vld in 1; csr_rd_vld in 1; csr_address in 16; csr_wr_data in 64; csr_rd_ack out 1; csr_rd_data out 64.

Function
REQ-011 SHALL write AEG[idx] with disp_aeg_wr_data on the edge where disp_aeg_wr=1 and idx<NA.
REQ-012 SHALL return AEG[idx] on disp_rtn_data, with disp_rtn_data_vld=1, exactly one cycle after disp_aeg_rd; idx>=NA returns 0.
REQ-013 SHALL assign fixed AEG roles: AEG[0] base address; AEG[1] GVT result; AEG[2] timeout limit (0 = disabled); AEG[3] run-cycle count.
REQ-014 SHALL pulse each exception bit for one cycle, registered one cycle after its cause:
  - bit0: disp_inst_vld with inst != 0.
  - bit1: AEG rd/wr with idx >= NA.
  - bit2: timeout.
  - bit3: CSR abort.
  - bits 15:4: always 0.
REQ-015 SHALL treat disp_inst_vld with inst==0 as START, registered one cycle (r_start).
REQ-016 SHALL implement the FSM:
  - IDLE -> START on r_start.
  - START -> RUNNING after 1 cycle; core_start=1 in START only.
  - RUNNING -> FINISHED on all-done, timeout or abort.
  - FINISHED -> IDLE after 1 cycle.
REQ-017 SHALL clear the per-core done latches and the run counter in START.
REQ-018 SHALL set core_run=1 in RUNNING only.
REQ-019 SHALL, in RUNNING, on core_done[i]=1, set done latch i and capture core_gvt slice i; later pulses from the same core SHALL overwrite the capture.
REQ-020 SHALL ignore core_done outside RUNNING.
REQ-021 SHALL, in RUNNING, increment the run counter every cycle, saturating at all-ones.
REQ-022 SHALL declare all-done when every done latch, including the one set this cycle, is 1.
REQ-023 SHALL declare timeout when AEG[2] != 0 and the counter equals AEG[2][CNT_W-1:0].
REQ-024 SHALL declare abort on csr_wr_vld at address 16'h0002; csr_wr_vld outside RUNNING SHALL have no effect.
REQ-025 SHALL resolve simultaneous events with priority all-done > abort > timeout; only the winning cause raises its exception bit.
REQ-026 SHALL compute the result GVT as the unsigned minimum over latched cores' captures, zero-extended to 64 bits; with no latched core, the result SHALL be 64'hFFFF_FFFF_FFFF_FFFF.
REQ-027 SHALL, in FINISHED, write AEG[1]=result and AEG[3]=counter.
REQ-028 SHALL give a same-cycle dispatcher write to AEG[1] or AEG[3] priority over the REQ-027 write.
REQ-029 SHALL drive disp_idle = (state==IDLE) && !r_start.
REQ-030 SHALL drive disp_stall = (state!=IDLE) || r_start || (disp_inst_vld && disp_inst==0).
REQ-031 SHALL ack CSR reads one cycle after csr_rd_vld.
REQ-032 SHALL return CSR read data by address:
  - 0: {60'b0, state[1:0], 2'b0}, with state encoding IDLE=0, START=1, RUNNING=2, FINISHED=3.
  - 1: AEG[1].
  - 3: counter.
  - 4: {zero, done latches}.
  - other addresses: 0.

Reset
REQ-033 SHALL, on i_reset, asynchronously clear all state: FSM=IDLE, AEGs, latches, captures, counter, r_start.
REQ-034 SHALL, during and immediately after reset, hold all registered outputs at 0 (disp_rtn_data_vld, disp_exception, core_start, core_run, csr_rd_ack, csr_rd_data, disp_rtn_data), with disp_idle=1 and disp_stall=0.
REQ-035 SHALL, on reset asserted mid-run, drop core_run the same cycle and perform no AEG[1]/AEG[3] update.

Verification
REQ-036 SHALL cover normal run: NUM_CORES=4, AEG[2]=0, START, cores done with gvt 40, 25, 31, 99 -> FINISHED, AEG[1]=25, disp_idle=1 next cycle, no exception.
REQ-037 SHALL cover timeout: AEG[2]=100, cores 0-1 done (gvt 7, 9), cores 2-3 silent -> FINISHED at counter=100, exception bit2 pulse, AEG[1]=7, AEG[3]=100.
REQ-038 SHALL cover simultaneous events: last core_done on the same cycle counter==AEG[2] -> normal completion, no bit2; separately, CSR abort with no cores done -> bit3, AEG[1]=all-ones.
REQ-039 SHALL cover AEG access: write idx 9 with NA=8 -> bit1 pulse, no AEG change; read idx 2 -> disp_rtn_data_vld and value exactly one cycle later; inst=5 -> bit0 pulse.
REQ-040 SHALL cover reset mid-run: i_reset asserted in RUNNING -> core_run=0 immediately, CSR addr 0 reads 0, AEG[1] stays 0.
